// File: rtl/adder_subtractor_stage_pkg.sv
// Shared definitions for the SAP-1 adder/subtractor stage: default width,
// controller flag-bus bit positions and the packed flag record.
package adder_subtractor_stage_pkg;

    localparam int WIDTH_DEFAULT = 8;

    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;

    // Field order places c at bit 0 so the FLAG_* indices address the packed value directly.
    typedef struct packed {
        logic v;
        logic n;
        logic z;
        logic c;
    } flags_t;

    function automatic flags_t make_flags(input logic c, input logic z,
                                          input logic n, input logic v);
        flags_t f;
        f.c = c;
        f.z = z;
        f.n = n;
        f.v = v;
        return f;
    endfunction

endpackage

// File: rtl/adder_subtractor_stage_nibble_adder.sv
// 4-bit binary full adder slice (74LS283 equivalent), chained through cin/cout
// to build the full-width adder.
module nibble_adder (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       cin_i,
    output logic [3:0] sum_o,
    output logic       cout_o
);

    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {4'b0000, cin_i};

endmodule

// File: rtl/adder_subtractor_stage.sv
// SAP-1 arithmetic stage: B register, A+B / A-B via a rippled nibble-adder chain,
// tri-state result drive onto the W bus and a registered c/z/n/v flag register.
module adder_subtractor_stage
    import adder_subtractor_stage_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             CLK,
    input  logic             CLR_bar,
    input  logic [WIDTH-1:0] bus_input,
    input  logic             L_B_bar,
    input  logic [WIDTH-1:0] a_input,
    input  logic             S_U,
    input  logic             E_U,
    input  logic             L_F_bar,
    output logic [WIDTH-1:0] bus_output,
    output logic [WIDTH-1:0] b_output,
    output logic             flag_c,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_v
);

    localparam int NIB = WIDTH / 4;

    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] result;
    logic [NIB:0]     carry;
    logic             ovf;
    flags_t           flags_q, flags_d;

    // Subtract is A + ~B + 1: the XOR stage complements B and S_U feeds the first carry-in.
    assign b_eff    = b_q ^ {WIDTH{S_U}};
    assign carry[0] = S_U;

    for (genvar i = 0; i < NIB; i++) begin : g_nib
        nibble_adder u_nib (
            .a_i   (a_input[4*i +: 4]),
            .b_i   (b_eff[4*i +: 4]),
            .cin_i (carry[i]),
            .sum_o (result[4*i +: 4]),
            .cout_o(carry[i+1])
        );
    end

    assign ovf = (a_input[WIDTH-1] == b_eff[WIDTH-1]) && (result[WIDTH-1] != a_input[WIDTH-1]);

    always_comb begin
        b_d = b_q;
        if (!L_B_bar) begin
            b_d = bus_input;
        end
    end

    // Flags capture the pre-edge result, so a simultaneous B load still reports the old B.
    always_comb begin
        flags_d = flags_q;
        if (!L_F_bar) begin
            flags_d = make_flags(carry[NIB], result == '0, result[WIDTH-1], ovf);
        end
    end

    always_ff @(posedge CLK or negedge CLR_bar) begin
        if (!CLR_bar) begin
            b_q     <= '0;
            flags_q <= '0;
        end else begin
            b_q     <= b_d;
            flags_q <= flags_d;
        end
    end

    assign bus_output = E_U ? result : {WIDTH{1'bz}};
    assign b_output   = b_q;
    assign flag_c     = flags_q[FLAG_C];
    assign flag_z     = flags_q[FLAG_Z];
    assign flag_n     = flags_q[FLAG_N];
    assign flag_v     = flags_q[FLAG_V];

endmodule

// File: tb/tb_adder_subtractor_stage.sv
// Directed bench for adder_subtractor_stage: expectations from an integer reference
// model are queued when stimulus is driven and popped when the outputs are sampled.
module tb_adder_subtractor_stage;

    logic       CLK = 1'b0;
    logic       CLR_bar;
    logic [7:0] bus_input;
    logic       L_B_bar;
    logic [7:0] a_input;
    logic       S_U;
    logic       E_U;
    logic       L_F_bar;
    logic [7:0] bus_output;
    logic [7:0] b_output;
    logic       flag_c, flag_z, flag_n, flag_v;

    adder_subtractor_stage #(.WIDTH(8)) dut (
        .CLK       (CLK),
        .CLR_bar   (CLR_bar),
        .bus_input (bus_input),
        .L_B_bar   (L_B_bar),
        .a_input   (a_input),
        .S_U       (S_U),
        .E_U       (E_U),
        .L_F_bar   (L_F_bar),
        .bus_output(bus_output),
        .b_output  (b_output),
        .flag_c    (flag_c),
        .flag_z    (flag_z),
        .flag_n    (flag_n),
        .flag_v    (flag_v)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string      tag;
        logic [7:0] bus;
        logic [7:0] b;
        logic [3:0] flags;   // {v,n,z,c}
    } exp_t;

    exp_t       sb[$];
    int         total  = 0;
    int         passed = 0;
    logic [7:0] b_m;
    logic [3:0] f_m;

    // Reference arithmetic done with plain integers rather than a complemented adder.
    task automatic model(input logic [7:0] a, input logic [7:0] b, input logic s,
                         output logic [7:0] r, output logic [3:0] f);
        int u, sa, sb_i, sr;
        logic c, v;
        sa   = int'($signed(a));
        sb_i = int'($signed(b));
        if (s) begin
            u  = int'(a) - int'(b);
            c  = (a >= b);
            sr = sa - sb_i;
        end else begin
            u  = int'(a) + int'(b);
            c  = (u > 255);
            sr = sa + sb_i;
        end
        r = u[7:0];
        v = (sr > 127) || (sr < -128);
        f = {v, r[7], (r == 8'h00), c};
    endtask

    task automatic push_exp(input string tag);
        exp_t e;
        logic [7:0] r;
        logic [3:0] f;
        model(a_input, b_m, S_U, r, f);
        e.tag   = tag;
        e.bus   = E_U ? r : 8'bzzzz_zzzz;
        e.b     = b_m;
        e.flags = f_m;
        sb.push_back(e);
    endtask

    task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check_out();
        exp_t e;
        logic [7:0] fl;
        if (sb.size() == 0) begin
            total++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        e  = sb.pop_front();
        fl = {4'b0000, flag_v, flag_n, flag_z, flag_c};
        cmp({e.tag, ".bus"},   bus_output, e.bus);
        cmp({e.tag, ".b"},     b_output,   e.b);
        cmp({e.tag, ".flags"}, fl,         {4'b0000, e.flags});
    endtask

    // Drive-then-sample: expectation queued at drive time, outputs sampled 1ns later.
    task automatic step(input string tag);
        push_exp(tag);
        #1;
        check_out();
    endtask

    task automatic clk_edge();
        logic [7:0] r;
        logic [3:0] f;
        if (CLR_bar) begin
            model(a_input, b_m, S_U, r, f);
            if (!L_F_bar) f_m = f;
            if (!L_B_bar) b_m = bus_input;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic load_b(input logic [7:0] v);
        bus_input = v;
        L_B_bar   = 1'b0;
        clk_edge();
        L_B_bar   = 1'b1;
    endtask

    task automatic load_f();
        L_F_bar = 1'b0;
        clk_edge();
        L_F_bar = 1'b1;
    endtask

    initial begin
        // 1: reset at time zero
        CLR_bar = 1'b0; bus_input = 8'h00; L_B_bar = 1'b1; a_input = 8'h00;
        S_U = 1'b0; E_U = 1'b1; L_F_bar = 1'b1;
        b_m = 8'h00; f_m = 4'h0;
        #2;
        step("reset");
        @(negedge CLK);
        CLR_bar   = 1'b1;
        bus_input = 8'h33;
        clk_edge();
        step("no_load");

        // 2: add
        load_b(8'h05);
        a_input = 8'h07; S_U = 1'b0;
        step("add_7_5");
        load_f();
        step("add_flags");

        // 3: subtract
        S_U = 1'b1;
        step("sub_7_5");
        load_f();
        step("sub_7_5_flags");
        load_b(8'h07);
        a_input = 8'h05;
        load_f();
        step("sub_5_7");
        load_b(8'h40);
        a_input = 8'h40;
        load_f();
        step("sub_40_40");

        // 4: wrap and overflow
        S_U = 1'b0;
        load_b(8'h01);
        a_input = 8'hFF;
        load_f();
        step("add_wrap");
        a_input = 8'h7F;
        load_f();
        step("add_ovf");
        a_input = 8'h80; S_U = 1'b1;
        load_f();
        step("sub_ovf");

        // 5: simultaneous B and flag load, then bus release
        S_U = 1'b0; a_input = 8'h10; bus_input = 8'h20;
        L_B_bar = 1'b0; L_F_bar = 1'b0;
        clk_edge();
        L_B_bar = 1'b1; L_F_bar = 1'b1;
        step("simul_load");
        E_U = 1'b0;
        step("bus_hiz");
        E_U = 1'b1;

        // 6: reset mid-operation with a load pending
        load_b(8'hAC);
        a_input = 8'hAC; S_U = 1'b1;
        load_f();
        step("pre_reset");
        bus_input = 8'h55; L_B_bar = 1'b0;
        @(negedge CLK);
        CLR_bar = 1'b0;
        b_m = 8'h00; f_m = 4'h0;
        step("async_clear");
        clk_edge();
        step("held_in_reset");
        @(negedge CLK);
        CLR_bar = 1'b1;
        step("released");
        clk_edge();
        L_B_bar = 1'b1;
        step("load_after_release");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
